// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: request/config and frame-control bundle of the UART TX sequencer.
// stop2 exists only when UART_TX_TWO_STOP_EN is defined.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
) ();
  localparam int IW = $clog2(DATA_WIDTH);

  logic          data_valid;
  logic          par_en;
`ifdef UART_TX_TWO_STOP_EN
  logic          stop2;
`endif
  logic          busy;
  logic          ser_load;
  logic          ser_en;
  logic [IW-1:0] bit_idx;
  logic [1:0]    mux_sel;
  logic          frame_done;

  modport master (
    output data_valid,
    output par_en,
`ifdef UART_TX_TWO_STOP_EN
    output stop2,
`endif
    input  busy,
    input  ser_load,
    input  ser_en,
    input  bit_idx,
    input  mux_sel,
    input  frame_done
  );

  modport slave (
    input  data_valid,
    input  par_en,
`ifdef UART_TX_TWO_STOP_EN
    input  stop2,
`endif
    output busy,
    output ser_load,
    output ser_en,
    output bit_idx,
    output mux_sel,
    output frame_done
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART TX frame sequencer (start, data, parity, stop).
// Define UART_TX_TWO_STOP_EN to add the optional second stop bit (stop2).
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_ctrl_if.slave tx
);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] bit_idx_q;
  logic [IW-1:0] bit_idx_d;
  logic          par_en_q;
  logic          par_en_d;
  logic          busy_q;
  logic          busy_d;
  logic          ser_en_q;
  logic          ser_en_d;
  logic          frame_done_q;
  logic          frame_done_d;
  logic [1:0]    mux_sel_q;
  logic [1:0]    mux_sel_d;
  logic          accept;
  logic          last_stop;

`ifdef UART_TX_TWO_STOP_EN
  logic          stop2_q;
  logic          stop2_d;
  logic          stop_cnt_q;
  logic          stop_cnt_d;
`endif

  // Must match the parity calculator's capture condition exactly.
  assign accept = tx.data_valid & ~busy_q & (state_q == IDLE);

  assign tx.ser_load   = accept;
  assign tx.busy       = busy_q;
  assign tx.ser_en     = ser_en_q;
  assign tx.bit_idx    = bit_idx_q;
  assign tx.mux_sel    = mux_sel_q;
  assign tx.frame_done = frame_done_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      bit_idx_q    <= '0;
      par_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      ser_en_q     <= 1'b0;
      mux_sel_q    <= 2'b00;
      frame_done_q <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q      <= 1'b0;
      stop_cnt_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      par_en_q     <= par_en_d;
      busy_q       <= busy_d;
      ser_en_q     <= ser_en_d;
      mux_sel_q    <= mux_sel_d;
      frame_done_q <= frame_done_d;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q      <= stop2_d;
      stop_cnt_q   <= stop_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = '0;
    par_en_d  = par_en_q;
`ifdef UART_TX_TWO_STOP_EN
    stop2_d    = stop2_q;
    stop_cnt_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = START;
          par_en_d = tx.par_en;
`ifdef UART_TX_TWO_STOP_EN
          stop2_d  = tx.stop2;
`endif
        end
      end
      START: state_d = DATA;
      DATA: begin
        if (bit_idx_q == LAST) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      PARITY: state_d = STOP;
      STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (stop2_q && !stop_cnt_q) begin
          stop_cnt_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // frame_done only in the final stop cycle of the frame.
`ifdef UART_TX_TWO_STOP_EN
  assign last_stop = ~stop2_q | stop_cnt_d;
`else
  assign last_stop = 1'b1;
`endif

  always_comb begin
    busy_d       = 1'b1;
    ser_en_d     = 1'b0;
    mux_sel_d    = 2'b00;
    frame_done_d = 1'b0;
    unique case (1'b1)
      (state_d == START): mux_sel_d = 2'b01;
      (state_d == DATA): begin
        mux_sel_d = 2'b10;
        ser_en_d  = 1'b1;
      end
      (state_d == PARITY): mux_sel_d = 2'b11;
      (state_d == STOP): frame_done_d = last_stop;
      default: busy_d = 1'b0;
    endcase
  end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmit path. Accepts a byte request and steps the TX datapath through start bit, DATA_WIDTH data bits, optional parity bit and stop bit.
- Drives the serializer shift/load controls and the parity calculator handshake (data_valid/busy), and selects the output mux source.
- Runs at one bit per CLK, in the TX clock domain, after the prescaler.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (2..16)

Ports:
- CLK  input  1  TX bit clock
- RST  input  1  synchronous reset, active-high
- data_valid  input  1  request to send; sampled only when busy=0
- par_en  input  1  config: 1 = include parity bit in frame; sampled at acceptance
- busy  output  1  frame in progress; feeds parity calc busy input and upstream handshake
- ser_load  output  1  one-cycle pulse: serializer/parity calc capture P_DATA
- ser_en  output  1  serializer shift enable, high during DATA state
- bit_idx  output  $clog2(DATA_WIDTH)  index of data bit currently on the line
- mux_sel  output  2  line source: 00 idle/stop (1), 01 start (0), 10 serial data, 11 parity
- frame_done  output  1  one-cycle pulse in the last stop-bit cycle

Behaviour:
- Reset: on a CLK edge with RST=1, force state=IDLE, busy=0, ser_en=0, bit_idx=0, mux_sel=00, frame_done=0, and clear latched par_en. Reset overrides everything, mid-frame included; the line returns to idle on the next cycle.
- accept = data_valid & ~busy & (state==IDLE).
- ser_load = accept. It is combinational and must be identical to the condition the parity calc uses to capture.
- States: IDLE, START, DATA, PARITY, STOP. All outputs except ser_load are registered from state.
- IDLE: busy=0, mux_sel=00. On accept, latch par_en into par_en_q and go to START.
- START: busy=1, mux_sel=01, one cycle, then go to DATA with bit_idx=0.
- DATA: busy=1, ser_en=1, mux_sel=10, bit_idx increments every cycle.
  - At bit_idx=DATA_WIDTH-1, go to PARITY if par_en_q=1, otherwise go to STOP.
  - bit_idx never wraps past DATA_WIDTH-1 and is held at 0 outside DATA.
- PARITY: busy=1, mux_sel=11, one cycle, then STOP.
- STOP: busy=1, mux_sel=00, frame_done=1 for that cycle, then IDLE.
- Latency: accept edge to START is 1 cycle. Frame occupancy (busy=1) is 1+DATA_WIDTH+par_en_q+1 cycles; the default is 11 cycles with parity and 10 without.
- Minimum spacing: at least one IDLE cycle (busy=0) between frames. A data_valid held high through a frame is accepted on the first IDLE cycle after STOP.
- data_valid while busy=1 is ignored, with no queueing.
- Changes to par_en while busy=1 do not affect the current frame.
- Illegal state encodings recover to IDLE.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN
- Defined:
  - Adds input stop2 (1 bit), latched at accept with par_en.
  - If stop2_q=1, STOP lasts 2 cycles, mux_sel=00 in both; frame_done pulses in the second cycle only.
  - busy length increases by 1.
- Undefined: port stop2 is absent and STOP is always 1 cycle.

Test Plan:
- Reset mid-frame: RST=1 during DATA with bit_idx=3 -> next cycle state IDLE, busy=0, mux_sel=00, ser_en=0, bit_idx=0. A following data_valid is accepted normally.
- Parity frame (DATA_WIDTH=8): par_en=1, data_valid pulse at cycle 0 -> ser_load=1 at cycle 0, then:
  - cycle 1: mux_sel=01
  - cycles 2-9: mux_sel=10, ser_en=1, bit_idx 0..7
  - cycle 10: mux_sel=11
  - cycle 11: mux_sel=00, frame_done=1
  - busy=1 for cycles 1-11, busy=0 at cycle 12.
- No-parity frame: par_en=0 -> no mux_sel=11 cycle, frame_done at cycle 10, busy high for 10 cycles.
- Request while busy: data_valid pulsed at cycle 5 of a frame -> no ser_load, frame unaffected. data_valid held high continuously -> second ser_load exactly one cycle after the first frame_done, with one busy=0 cycle between frames.
- Config change mid-frame: par_en toggles 1->0 during DATA -> PARITY cycle still occurs. The next frame samples the new value (no parity).
- UART_TX_TWO_STOP_EN with stop2=1, par_en=1 -> mux_sel=00 for cycles 11-12, frame_done only at cycle 12, busy falls at cycle 13.
